// File: rtl/gpu_timing_gen_if.sv
// Raster timing bundle: advance enable in, counters/flags/sync/strobes out.
// frame_count exists only when GPU_TIMING_FRAME_COUNT_EN is defined.
interface gpu_timing_gen_if #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned FRAME_W = 8
);
  logic             en;
  logic [CNT_W-1:0] hcounter;
  logic [CNT_W-1:0] vcounter;
  logic             hvisible;
  logic             vvisible;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
  logic             vblank_start;
`ifdef GPU_TIMING_FRAME_COUNT_EN
  logic [FRAME_W-1:0] frame_count;
`endif

  if (CNT_W < 1 || FRAME_W < 1) begin : g_width_chk
    $error("gpu_timing_gen_if: CNT_W and FRAME_W must be >= 1");
  end

`ifdef GPU_TIMING_FRAME_COUNT_EN
  modport master (
    input  en,
    output hcounter, vcounter, hvisible, vvisible, hsync, vsync,
           line_start, frame_start, vblank_start, frame_count
  );
  modport slave (
    output en,
    input  hcounter, vcounter, hvisible, vvisible, hsync, vsync,
           line_start, frame_start, vblank_start, frame_count
  );
`else
  modport master (
    input  en,
    output hcounter, vcounter, hvisible, vvisible, hsync, vsync,
           line_start, frame_start, vblank_start
  );
  modport slave (
    output en,
    input  hcounter, vcounter, hvisible, vvisible, hsync, vsync,
           line_start, frame_start, vblank_start
  );
`endif
endinterface

// File: rtl/gpu_timing_gen.sv
// Parametrised raster timing generator with clock enable and event strobes.
// Optional frame counter compiled in with GPU_TIMING_FRAME_COUNT_EN.
module gpu_timing_gen #(
  parameter int unsigned H_VISIBLE  = 320,
  parameter int unsigned H_FRONT    = 8,
  parameter int unsigned H_SYNC     = 48,
  parameter int unsigned H_BACK     = 24,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input logic            clk,
  input logic            rst,
  gpu_timing_gen_if.master tg
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      CNT_W < 1 || FRAME_W < 1) begin : g_width_chk
    $error("gpu_timing_gen: every timing/width parameter must be >= 1");
  end
  if (CNT_W > 31 || (64'(1) << CNT_W) < 64'(H_TOTAL) ||
      (64'(1) << CNT_W) < 64'(V_TOTAL)) begin : g_cnt_chk
    $error("gpu_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  always_comb begin
    h_wrap = (tg.hcounter == H_LAST);
    v_wrap = (tg.vcounter == V_LAST);
    h_next = h_wrap ? '0 : tg.hcounter + CNT_W'(1);
    v_next = tg.vcounter;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : tg.vcounter + CNT_W'(1);
    end
  end

  // Flags and sync are decoded from the next counter values so they stay
  // aligned with the registered counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tg.hcounter     <= '0;
      tg.vcounter     <= '0;
      tg.hvisible     <= 1'b1;
      tg.vvisible     <= 1'b1;
      tg.hsync        <= ~H_SYNC_POL;
      tg.vsync        <= ~V_SYNC_POL;
      tg.line_start   <= 1'b0;
      tg.frame_start  <= 1'b0;
      tg.vblank_start <= 1'b0;
    end else begin
      tg.line_start   <= 1'b0;
      tg.frame_start  <= 1'b0;
      tg.vblank_start <= 1'b0;
      if (tg.en) begin
        tg.hcounter     <= h_next;
        tg.vcounter     <= v_next;
        tg.hvisible     <= (h_next < H_VIS_C);
        tg.vvisible     <= (v_next < V_VIS_C);
        tg.hsync        <= (h_next >= HS_BEG && h_next < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
        tg.vsync        <= (v_next >= VS_BEG && v_next < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
        tg.line_start   <= h_wrap;
        tg.frame_start  <= h_wrap && v_wrap;
        tg.vblank_start <= h_wrap && (v_next == V_VIS_C);
      end
    end
  end

`ifdef GPU_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tg.frame_count <= '0;
    end else if (tg.en && h_wrap && v_wrap) begin
      tg.frame_count <= tg.frame_count + FRAME_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_gpu_timing_gen.sv
// Bench for gpu_timing_gen: small raster, random en/rst, reference model
// derived from the count of advancing edges since reset.
module tb_gpu_timing_gen;
    localparam int unsigned HV = 10, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VV = 6,  VF = 2, VS = 2, VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int unsigned CW = 5;
    localparam int unsigned FW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpu_timing_gen_if #(.CNT_W(CW), .FRAME_W(FW)) tg ();

    gpu_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
        .CNT_W(CW), .FRAME_W(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tg(tg.master)
    );

    int checks = 0;
    int errors = 0;
    longint unsigned adv = 0;
    bit advanced = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        longint unsigned h, v, fr;
        h  = adv % HT;
        v  = (adv / HT) % VT;
        fr = adv / FRAME;
        chk("hcounter", 64'(tg.hcounter), 64'(h));
        chk("vcounter", 64'(tg.vcounter), 64'(v));
        chk("hvisible", 64'(tg.hvisible), 64'(h < HV));
        chk("vvisible", 64'(tg.vvisible), 64'(v < VV));
        chk("hsync", 64'(tg.hsync), 64'((h >= HV + HF && h < HV + HF + HS) ? HPOL : !HPOL));
        chk("vsync", 64'(tg.vsync), 64'((v >= VV + VF && v < VV + VF + VS) ? VPOL : !VPOL));
        chk("line_start", 64'(tg.line_start), 64'(advanced && h == 0));
        chk("frame_start", 64'(tg.frame_start), 64'(advanced && h == 0 && v == 0));
        chk("vblank_start", 64'(tg.vblank_start), 64'(advanced && h == 0 && v == VV));
`ifdef GPU_TIMING_FRAME_COUNT_EN
        chk("frame_count", 64'(tg.frame_count), 64'(fr % (64'(1) << FW)));
`endif
    endtask

    // Inputs change at the falling edge; the model applies them at the rising edge.
    task automatic step(input bit r, input bit e);
        rst = r;
        tg.en = e;
        @(posedge clk);
        if (r) begin
            adv = 0;
            advanced = 1'b0;
        end else if (e) begin
            adv++;
            advanced = 1'b1;
        end else begin
            advanced = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit found;
        tg.en = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Full rate for two frames plus a little.
        for (int i = 0; i < 2 * FRAME + 5; i++) step(1'b0, 1'b1);

        // Half rate, from a fresh reset.
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end

        // Reset in the middle of a frame.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (adv % HT == 7 && (adv / HT) % VT == 3) found = 1'b1;
            else step(1'b0, 1'b1);
        end
        chk("reach_mid_frame", 64'(found), 64'(1));
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Random enable with occasional reset.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
